// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch controller: synchronised buttons, IDLE/RUN/STOP/SPLIT FSM,
// saturating elapsed-tick counter, split freeze register and lap table.
module stopwatch_lap_ctrl #(
  parameter int CNT_W     = 24,
  parameter int LAP_DEPTH = 8,
  parameter int SYNC_STG  = 2,
  localparam int LW       = $clog2(LAP_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             split_i,
  input  logic             lap_i,
  input  logic             clr_i,
  input  logic [LW-1:0]    lap_rd_idx_i,
  output logic [CNT_W-1:0] lap_rd_data_o,
  output logic [LW:0]      lap_cnt_o,
  output logic             lap_full_o,
  output logic [CNT_W-1:0] time_o,
  output logic [CNT_W-1:0] disp_o,
  output logic             en_o,
  output logic             update_o,
  output logic             ovf_o,
  output logic [1:0]       state_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STOP  = 2'd2;
  localparam logic [1:0] ST_SPLIT = 2'd3;
  localparam int NB = 5;

  // Button vector bit order: 0 start, 1 stop, 2 split, 3 lap, 4 clr
  logic [NB-1:0]          btn;
  logic [SYNC_STG*NB-1:0] sync_reg;
  logic [NB-1:0]          prev_reg;
  logic [NB-1:0]          sync_last;
  logic [NB-1:0]          pulse;

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] time_reg;
  logic [CNT_W-1:0] frozen_reg;
  logic             ovf_reg;
  logic [LW:0]      lap_cnt_reg;
  logic [CNT_W-1:0] rd_data_reg;
  logic [CNT_W-1:0] lap_mem [LAP_DEPTH];

  logic clr_evt;
  logic lap_evt;
  logic running;
  logic full;
  logic lap_wr;

  assign btn       = {clr_i, lap_i, split_i, stop_i, start_i};
  assign sync_last = sync_reg[SYNC_STG*NB-1 -: NB];
  assign pulse     = sync_last & ~prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
      prev_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[(SYNC_STG-1)*NB-1:0], btn};
      prev_reg <= sync_last;
    end
  end

  assign running = (state_reg == ST_RUN) || (state_reg == ST_SPLIT);
  assign full    = (lap_cnt_reg == (LW+1)'(LAP_DEPTH));

  // Only the highest-priority pulse is considered; lower ones are dropped
  // even when the winner has no effect in the current state.
  always_comb begin
    state_next = state_reg;
    clr_evt    = 1'b0;
    if (pulse[4]) begin
      if (state_reg == ST_STOP) begin
        state_next = ST_IDLE;
        clr_evt    = 1'b1;
      end
    end else if (pulse[2]) begin
      if (state_reg == ST_RUN)        state_next = ST_SPLIT;
      else if (state_reg == ST_SPLIT) state_next = ST_RUN;
    end else if (pulse[1]) begin
      if (running) state_next = ST_STOP;
    end else if (pulse[0]) begin
      if ((state_reg == ST_IDLE) || (state_reg == ST_STOP)) state_next = ST_RUN;
    end
    lap_evt = pulse[3] && ((state_next == ST_RUN) || (state_next == ST_SPLIT));
  end

  assign lap_wr = lap_evt && !full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      time_reg    <= '0;
      frozen_reg  <= '0;
      ovf_reg     <= 1'b0;
      lap_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (clr_evt) begin
        time_reg    <= '0;
        frozen_reg  <= '0;
        ovf_reg     <= 1'b0;
        lap_cnt_reg <= '0;
      end else begin
        if (running && tick_i) begin
          if (&time_reg) ovf_reg  <= 1'b1;
          else           time_reg <= time_reg + 1'b1;
        end
        // Capture the count as it stood before this edge's tick
        if ((state_next == ST_SPLIT) && (state_reg != ST_SPLIT))
          frozen_reg <= time_reg;
        if (lap_wr)
          lap_cnt_reg <= lap_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (lap_wr)
      lap_mem[lap_cnt_reg[LW-1:0]] <= time_reg;
  end

  // Entries at or beyond the fill level read as zero, which also covers a
  // same-cycle write to the entry being read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_data_reg <= '0;
    else if ({1'b0, lap_rd_idx_i} < lap_cnt_reg)
      rd_data_reg <= lap_mem[lap_rd_idx_i];
    else
      rd_data_reg <= '0;
  end

  assign lap_rd_data_o = rd_data_reg;
  assign lap_cnt_o     = lap_cnt_reg;
  assign lap_full_o    = full;
  assign time_o        = time_reg;
  assign disp_o        = (state_reg == ST_SPLIT) ? frozen_reg : time_reg;
  assign en_o          = running;
  assign update_o      = (state_reg != ST_SPLIT);
  assign ovf_o         = ovf_reg;
  assign state_o       = state_reg;

endmodule
